// File: rtl/ntr_responder.sv
// NTR data-phase responder: decodes a captured 8-byte command and streams the
// response bytes one per host strobe, prefetching ROM bytes through a 2-entry buffer.
module ntr_responder #(
    parameter logic [31:0] CHIP_ID     = 32'h00001FC2,
    parameter int          XFER_BYTES  = 512,
    parameter int          DUMMY_BYTES = 8192
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs1,
    input  logic [63:0] command,
    input  logic        cmd_ready,
    input  logic        rd_strobe,
    output logic [7:0]  dout,
    output logic        dout_valid,
    output logic        busy,
    output logic        done,
    output logic        unknown_cmd,
    output logic        underrun,
    output logic [31:0] rom_addr,
    output logic        rom_req,
    input  logic        rom_ack,
    input  logic [7:0]  rom_data
);

    localparam logic [15:0] XFER_CNT  = 16'(XFER_BYTES);
    localparam logic [15:0] DUMMY_CNT = 16'(DUMMY_BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_SERVE,
        S_ABORT_WAIT
    } state_t;

    typedef enum logic [1:0] {
        SRC_FF,
        SRC_CHIP,
        SRC_ROM
    } src_t;

    state_t      r_state;
    src_t        r_src;
    logic        r_cmdPrev;
    logic [39:0] r_cmd;
    logic [31:0] r_base;
    logic [15:0] r_total;
    logic [15:0] r_fetched;
    logic [15:0] r_remaining;
    logic [7:0]  r_dout;
    logic        r_doutValid;
    logic [7:0]  r_pre;
    logic        r_preValid;
    logic        r_done;
    logic        r_unknown;
    logic        r_underrun;
    logic [31:0] r_romAddr;
    logic        r_romReq;

    logic        w_cmdEdge;
    logic [7:0]  w_opcode;
    logic [31:0] w_cmdBase;
    logic        w_pop;
    logic        w_ack;
    logic [7:0]  w_patByte;
    logic        w_patValid;
    logic        w_inValid;
    logic [7:0]  w_inByte;
    logic        w_issue;
    logic        w_unusedCmdBits;

    function automatic logic isKnown(input logic [7:0] op);
        return op inside {8'h9F, 8'h90, 8'hB8, 8'h00, 8'hB7};
    endfunction

    assign w_unusedCmdBits = &command[63:40];

    assign w_cmdEdge  = cmd_ready & ~r_cmdPrev;
    assign w_opcode   = r_cmd[7:0];
    assign w_cmdBase  = {r_cmd[15:8], r_cmd[23:16], r_cmd[31:24], r_cmd[39:32]};
    assign w_pop      = rd_strobe & r_doutValid;
    assign w_ack      = r_romReq & rom_ack;
    assign w_patByte  = (r_src == SRC_CHIP) ? CHIP_ID[{r_fetched[1:0], 3'b000} +: 8] : 8'hFF;
    assign w_patValid = (r_src != SRC_ROM) && (r_fetched < r_total) && !r_preValid;
    assign w_inValid  = (r_src == SRC_ROM) ? w_ack : w_patValid;
    assign w_inByte   = (r_src == SRC_ROM) ? rom_data : w_patByte;
    // Only one ROM request may be in flight, and only while the prefetch slot is free.
    assign w_issue    = (r_src == SRC_ROM) && !r_romReq && !r_preValid && (r_fetched < r_total);

    // A command still held across reset must not be replayed, so the edge
    // detector comes out of reset as if cmd_ready had been high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_src       <= SRC_FF;
            r_cmdPrev   <= 1'b1;
            r_cmd       <= '0;
            r_base      <= '0;
            r_total     <= '0;
            r_fetched   <= '0;
            r_remaining <= '0;
            r_dout      <= 8'h00;
            r_doutValid <= 1'b0;
            r_pre       <= 8'h00;
            r_preValid  <= 1'b0;
            r_done      <= 1'b0;
            r_unknown   <= 1'b0;
            r_underrun  <= 1'b0;
            r_romAddr   <= '0;
            r_romReq    <= 1'b0;
        end else begin
            r_cmdPrev <= cmd_ready;
            r_done    <= 1'b0;
            r_unknown <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cmdEdge && !cs1) begin
                        r_state    <= S_DECODE;
                        r_cmd      <= command[39:0];
                        r_unknown  <= !isKnown(command[7:0]);
                        r_underrun <= 1'b0;
                    end
                end
                S_DECODE: begin
                    if (cs1) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_SERVE;
                        if (rd_strobe) r_underrun <= 1'b1;
                        case (w_opcode)
                            8'h9F: begin
                                r_src       <= SRC_FF;
                                r_total     <= DUMMY_CNT;
                                r_remaining <= DUMMY_CNT;
                                r_dout      <= 8'hFF;
                                r_doutValid <= 1'b1;
                                r_fetched   <= 16'd1;
                            end
                            8'h90, 8'hB8: begin
                                r_src       <= SRC_CHIP;
                                r_total     <= 16'd4;
                                r_remaining <= 16'd4;
                                r_dout      <= CHIP_ID[7:0];
                                r_doutValid <= 1'b1;
                                r_fetched   <= 16'd1;
                            end
                            8'h00, 8'hB7: begin
                                r_src       <= SRC_ROM;
                                r_total     <= XFER_CNT;
                                r_remaining <= XFER_CNT;
                                r_fetched   <= 16'd0;
                                r_base      <= (w_opcode == 8'hB7) ? w_cmdBase : 32'h0;
                                r_romAddr   <= (w_opcode == 8'hB7) ? w_cmdBase : 32'h0;
                                r_romReq    <= 1'b1;
                            end
                            default: begin
                                r_src       <= SRC_FF;
                                r_total     <= XFER_CNT;
                                r_remaining <= XFER_CNT;
                                r_dout      <= 8'hFF;
                                r_doutValid <= 1'b1;
                                r_fetched   <= 16'd1;
                            end
                        endcase
                    end
                end
                S_SERVE: begin
                    if (cs1) begin
                        r_doutValid <= 1'b0;
                        r_preValid  <= 1'b0;
                        if (r_romReq && !rom_ack) begin
                            r_state <= S_ABORT_WAIT;
                        end else begin
                            r_romReq <= 1'b0;
                            r_state  <= S_IDLE;
                        end
                    end else begin
                        if (rd_strobe && !r_doutValid) r_underrun <= 1'b1;
                        if (w_inValid) r_fetched <= r_fetched + 16'd1;
                        if (w_ack) begin
                            r_romReq <= 1'b0;
                        end else if (w_issue) begin
                            r_romReq  <= 1'b1;
                            r_romAddr <= {r_base[31:12], r_base[11:0] + r_fetched[11:0]};
                        end
                        // Output register refills from prefetch first, then from the incoming byte.
                        if (w_pop) begin
                            if (r_preValid) begin
                                r_dout <= r_pre;
                                if (w_inValid) r_pre <= w_inByte;
                                else           r_preValid <= 1'b0;
                            end else if (w_inValid) begin
                                r_dout <= w_inByte;
                            end else begin
                                r_doutValid <= 1'b0;
                            end
                        end else if (w_inValid) begin
                            if (r_doutValid) begin
                                r_pre      <= w_inByte;
                                r_preValid <= 1'b1;
                            end else begin
                                r_dout      <= w_inByte;
                                r_doutValid <= 1'b1;
                            end
                        end
                        if (w_pop) begin
                            r_remaining <= r_remaining - 16'd1;
                            if (r_remaining == 16'd1) begin
                                r_done      <= 1'b1;
                                r_doutValid <= 1'b0;
                                r_preValid  <= 1'b0;
                                r_state     <= S_IDLE;
                            end
                        end
                    end
                end
                S_ABORT_WAIT: begin
                    if (rom_ack) begin
                        r_romReq <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dout        = r_dout;
    assign dout_valid  = r_doutValid;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign unknown_cmd = r_unknown;
    assign underrun    = r_underrun;
    assign rom_addr    = r_romAddr;
    assign rom_req     = r_romReq;

endmodule

// File: tb/tb_ntr_responder.sv
// Directed bench for ntr_responder: a table of whole transactions checked against
// a small byte/address model, plus hand sequences for latency, abort, underrun and reset.
module tb_ntr_responder;

    localparam logic [31:0] CHIP = 32'h00001FC2;

    typedef enum int {K_FF, K_CHIP, K_ROM} kind_t;

    typedef struct {
        logic [63:0] cmd;
        kind_t       kind;
        logic [31:0] base;
        int          romDelay;
        int          stride;
        int          expLen;
        logic        expUnknown;
        logic [31:0] expFirst;
        logic [31:0] expAddr2;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs1;
    logic [63:0] command;
    logic        cmd_ready;
    logic        rd_strobe;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        busy;
    logic        done;
    logic        unknown_cmd;
    logic        underrun;
    logic [31:0] rom_addr;
    logic        rom_req;
    logic        rom_ack;
    logic [7:0]  rom_data;

    int compared = 0;
    int mismatched = 0;
    int romDelay = 0;
    int romWait = 0;
    int ackCount = 0;
    int popCount = 0;
    int doneCount = 0;
    int unknownCount = 0;
    int romUnstable = 0;
    int reqDropEarly = 0;
    logic        prevReq = 1'b0;
    logic        prevAck = 1'b0;
    logic [31:0] prevAddr = '0;
    logic [31:0] addrQ[$];
    logic [7:0]  gotQ[$];
    vec_t        vecs[9];

    always #5 clk = ~clk;

    ntr_responder #(.CHIP_ID(CHIP), .XFER_BYTES(512), .DUMMY_BYTES(8192)) dut (
        .clk(clk), .rst_n(rst_n), .cs1(cs1), .command(command), .cmd_ready(cmd_ready),
        .rd_strobe(rd_strobe), .dout(dout), .dout_valid(dout_valid), .busy(busy),
        .done(done), .unknown_cmd(unknown_cmd), .underrun(underrun), .rom_addr(rom_addr),
        .rom_req(rom_req), .rom_ack(rom_ack), .rom_data(rom_data)
    );

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] modelAddr(input logic [31:0] base, input int i);
        logic [31:0] sum;
        sum = base + 32'(i);
        return (base & 32'hFFFF_F000) | (sum & 32'h0000_0FFF);
    endfunction

    function automatic logic [7:0] modelByte(input vec_t v, input int i);
        logic [31:0] a;
        case (v.kind)
            K_CHIP:  return 8'(CHIP >> (8 * i));
            K_ROM: begin
                a = modelAddr(v.base, i);
                return a[7:0];
            end
            default: return 8'hFF;
        endcase
    endfunction

    // One clock: advance to just after the edge, tally pulses, then run the ROM responder.
    task automatic tick();
        @(posedge clk);
        #1;
        if (done) doneCount++;
        if (unknown_cmd) unknownCount++;
        if (rom_req && prevReq && !prevAck && rom_addr != prevAddr) romUnstable++;
        if (prevReq && !prevAck && !rom_req && rst_n) reqDropEarly++;
        if (rom_ack) begin
            rom_ack = 1'b0;
        end else if (rom_req) begin
            if (romWait >= romDelay) begin
                rom_ack  = 1'b1;
                rom_data = rom_addr[7:0];
                addrQ.push_back(rom_addr);
                ackCount++;
                romWait = 0;
            end else begin
                romWait++;
            end
        end
        prevReq  = rom_req;
        prevAck  = rom_ack;
        prevAddr = rom_addr;
    endtask

    task automatic startCmd(input logic [63:0] c);
        cmd_ready = 1'b0;
        command   = c;
        tick();
        cmd_ready = 1'b1;
        tick();
    endtask

    task automatic collect(input int stride, input int expLen, output int n, output int bufMax);
        int cyc = 0;
        n = 0;
        bufMax = 0;
        gotQ.delete();
        while (n < expLen && cyc < expLen * 16 + 64) begin
            if (ackCount - popCount > bufMax) bufMax = ackCount - popCount;
            rd_strobe = dout_valid && (cyc % stride == 0);
            if (rd_strobe) begin
                gotQ.push_back(dout);
                popCount++;
                n++;
            end
            tick();
            cyc++;
        end
        rd_strobe = 1'b0;
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        int n, bufMax, u0, d0, errs;
        logic [31:0] first;
        romDelay = v.romDelay;
        romWait  = 0;
        addrQ.delete();
        ackCount = 0;
        popCount = 0;
        u0 = unknownCount;
        d0 = doneCount;
        startCmd(v.cmd);
        collect(v.stride, v.expLen, n, bufMax);
        checkOutput($sformatf("v%0d_unknown_pulses", idx), 64'(unknownCount - u0), 64'(v.expUnknown));
        checkOutput($sformatf("v%0d_length", idx), 64'(n), 64'(v.expLen));
        first = '0;
        for (int k = 0; k < 4; k++)
            if (k < gotQ.size()) first[8*k +: 8] = gotQ[k];
        checkOutput($sformatf("v%0d_first_bytes", idx), 64'(first), 64'(v.expFirst));
        errs = 0;
        for (int k = 0; k < gotQ.size(); k++)
            if (gotQ[k] !== modelByte(v, k)) errs++;
        checkOutput($sformatf("v%0d_stream_errors", idx), 64'(errs), 64'd0);
        checkOutput($sformatf("v%0d_done_busy_end", idx), {62'd0, done, busy}, 64'd2);
        checkOutput($sformatf("v%0d_done_count", idx), 64'(doneCount - d0), 64'd1);
        checkOutput($sformatf("v%0d_underrun", idx), 64'(underrun), 64'd0);
        if (v.kind == K_ROM) begin
            checkOutput($sformatf("v%0d_buffer_over2", idx), 64'(bufMax > 2), 64'd0);
            checkOutput($sformatf("v%0d_rom_fetches", idx), 64'(addrQ.size()), 64'(v.expLen));
            errs = 0;
            for (int k = 0; k < addrQ.size(); k++)
                if (addrQ[k] !== modelAddr(v.base, k)) errs++;
            checkOutput($sformatf("v%0d_addr_errors", idx), 64'(errs), 64'd0);
            checkOutput($sformatf("v%0d_addr2", idx), (addrQ.size() > 2) ? 64'(addrQ[2]) : 64'hDEAD, 64'(v.expAddr2));
        end
    endtask

    initial begin
        int n, bufMax, d0, cnt;
        logic seen;

        vecs[0] = '{64'h90,                  K_CHIP, 32'h0,        0, 1, 4,    1'b0, 32'h00001FC2, 32'h0};
        vecs[1] = '{64'hB8,                  K_CHIP, 32'h0,        0, 2, 4,    1'b0, 32'h00001FC2, 32'h0};
        vecs[2] = '{64'h9F,                  K_FF,   32'h0,        0, 1, 8192, 1'b0, 32'hFFFFFFFF, 32'h0};
        vecs[3] = '{64'h00,                  K_ROM,  32'h0,        3, 4, 512,  1'b0, 32'h03020100, 32'h00000002};
        vecs[4] = '{64'h000000FE_0F0000B7,   K_ROM,  32'h00000FFE, 0, 1, 512,  1'b0, 32'h0100FFFE, 32'h00000000};
        vecs[5] = '{64'h00000078_563412B7,   K_ROM,  32'h12345678, 1, 3, 512,  1'b0, 32'h7B7A7978, 32'h1234567A};
        vecs[6] = '{64'h3C,                  K_FF,   32'h0,        0, 1, 512,  1'b1, 32'hFFFFFFFF, 32'h0};
        vecs[7] = '{64'hFFFFFFFF_FFFFEFAB,   K_FF,   32'h0,        0, 2, 512,  1'b1, 32'hFFFFFFFF, 32'h0};
        vecs[8] = '{64'h000000FF_EFCDABB7,   K_ROM,  32'hABCDEFFF, 2, 1, 512,  1'b0, 32'h020100FF, 32'hABCDE001};

        rst_n = 1'b0; cs1 = 1'b0; command = '0; cmd_ready = 1'b0;
        rd_strobe = 1'b0; rom_ack = 1'b0; rom_data = 8'h00;
        tick();
        tick();
        checkOutput("reset_outputs",
                    64'({dout, dout_valid, busy, done, unknown_cmd, underrun, rom_req, rom_addr}), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) applyStimulus(i, vecs[i]);

        // Fixed-pattern latency, then a held cmd_ready level must not restart.
        startCmd(64'h90);
        checkOutput("chip_decode_cycle", {62'd0, busy, dout_valid}, 64'd2);
        tick();
        checkOutput("chip_first_byte", {55'd0, dout_valid, dout}, {55'd0, 1'b1, 8'hC2});
        collect(1, 4, n, bufMax);
        checkOutput("chip_len", 64'(n), 64'd4);
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            seen |= busy;
        end
        checkOutput("level_high_ignored", 64'(seen), 64'd0);

        // ROM latency, then abort with a request outstanding.
        romDelay = 2; romWait = 0;
        startCmd(64'h00);
        checkOutput("rom_req_in_decode", 64'(rom_req), 64'd0);
        tick();
        checkOutput("rom_req_after_decode", {31'd0, rom_req, dout_valid, rom_addr}, {31'd0, 1'b1, 1'b0, 32'h0});
        cnt = 0;
        while (!rom_ack && cnt < 20) begin tick(); cnt++; end
        tick();
        checkOutput("rom_first_byte", {55'd0, dout_valid, dout}, {55'd0, 1'b1, 8'h00});
        romDelay = 5;
        cnt = 0;
        while (!rom_req && cnt < 20) begin tick(); cnt++; end
        d0 = doneCount;
        cs1 = 1'b1;
        tick();
        checkOutput("abort_next_cycle", {61'd0, dout_valid, busy, rom_req}, 64'd3);
        cnt = 0;
        while (busy && cnt < 30) begin tick(); cnt++; end
        checkOutput("abort_to_idle", {62'd0, busy, rom_req}, 64'd0);
        checkOutput("abort_no_done", 64'(doneCount - d0), 64'd0);
        cs1 = 1'b0;

        // Strobe during DECODE sets underrun; next decode clears it.
        romDelay = 1; romWait = 0;
        startCmd(64'h00);
        rd_strobe = 1'b1;
        tick();
        rd_strobe = 1'b0;
        checkOutput("underrun_set", 64'(underrun), 64'd1);
        cs1 = 1'b1;
        cnt = 0;
        while (busy && cnt < 30) begin tick(); cnt++; end
        checkOutput("underrun_sticky_idle", {62'd0, busy, underrun}, 64'd1);
        cs1 = 1'b0;
        startCmd(64'h90);
        checkOutput("underrun_cleared", {62'd0, underrun, unknown_cmd}, 64'd0);
        collect(1, 4, n, bufMax);
        checkOutput("after_underrun_len", 64'(n), 64'd4);

        // Asynchronous reset between edges during a dummy stream.
        startCmd(64'h9F);
        rd_strobe = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        rd_strobe = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs",
                    64'({dout, dout_valid, busy, done, unknown_cmd, underrun, rom_req, rom_addr}), 64'd0);
        #2 rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            seen |= busy | dout_valid;
        end
        checkOutput("quiet_after_reset", 64'(seen), 64'd0);
        startCmd(64'hB8);
        checkOutput("restart_after_reset", 64'(busy), 64'd1);
        collect(1, 4, n, bufMax);
        checkOutput("restart_len", 64'(n), 64'd4);

        checkOutput("rom_addr_stability", 64'(romUnstable), 64'd0);
        checkOutput("rom_req_held_until_ack", 64'(reqDropEarly), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
